mips_reg_bank_p: RTL
====================

MIPS_REG_BANK_P -- requirements
Module: mips_reg_bank_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of registers, 2..64.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter INIT_MODE, default 1: init sweep value; 0 = zero, 1 = register index.
REQ-005 SHALL define AW = $clog2(NREGS) as a derived localparam.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_addr  input  AW  write register index.
REQ-011 wr_data  input  DATA_W  write data.
REQ-012 rd_addr  input  NRD*AW  packed read indices; port i uses bits [i*AW +: AW].
REQ-013 rd_data  output  NRD*DATA_W  packed combinational read data.
REQ-014 init_req  input  1  pulse that starts a re-initialisation sweep.
REQ-015 clr_drop  input  1  clears wr_drop.
REQ-016 busy  output  1  high while the init sweep is running.
REQ-017 wr_drop  output  1  sticky flag: a write was discarded during the sweep.

Function
REQ-018 SHALL implement a two-state FSM, INIT and IDLE.
REQ-019 INIT SHALL write one register per cycle at index cnt, with value 0 (INIT_MODE=0) or cnt zero-extended to DATA_W (INIT_MODE=1), then increment cnt.
REQ-020 INIT SHALL go to IDLE in the cycle after writing index NREGS-1, so busy is high for exactly NREGS cycles.
REQ-021 In IDLE, init_req=1 SHALL clear cnt and enter INIT on the next edge; init_req in INIT SHALL be ignored and SHALL NOT restart the count.
REQ-022 An IDLE write with wr_en=1 and 0 < wr_addr < NREGS SHALL update the register on the rising edge.
REQ-023 Writes to R0 SHALL be discarded silently, with no wr_drop; R0 SHALL always read 0.
REQ-024 Writes with wr_addr >= NREGS SHALL be discarded silently, and reads with index >= NREGS SHALL return 0.
REQ-025 wr_en=1 during INIT SHALL be discarded and SHALL set wr_drop on the next edge.
REQ-026 wr_drop SHALL stay set until clr_drop=1; if clr_drop and a dropped write occur in the same cycle, set SHALL win.
REQ-027 Read ports SHALL be combinational and independent; the same index on several ports SHALL return identical data.
REQ-028 Bypass: in IDLE, if wr_en=1 and wr_addr equals a port's nonzero, in-range rd_addr, that port SHALL return wr_data in the same cycle.
REQ-029 While busy=1, all rd_data SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force state INIT, cnt=0, busy=1, wr_drop=0, and rd_data=0.
REQ-031 Register contents need no reset; the sweep defines them before busy falls.
REQ-032 Reset asserted mid-sweep or mid-write SHALL abort it, and the sweep SHALL restart from index 0 after release.

Verification
REQ-033 Release reset, defaults -> busy=1 for 32 cycles then 0; rd_addr={R3,R5} -> rd_data={3,5}; wr_drop=0.
REQ-034 IDLE: wr_en=1, wr_addr=4, wr_data=30, rd_addr port0=4 same cycle -> port0=30 (bypass); next cycle without write -> 30.
REQ-035 IDLE: write R0=0xFFFF_FFFF -> R0 reads 0, wr_drop=0; NREGS=20, read index 25 -> 0.
REQ-036 Pulse init_req after writing R7=99; write R7=55 during the sweep -> wr_drop=1, R7 reads 7 after busy falls; clr_drop -> wr_drop=0.
REQ-037 Reset at cnt=10, held 2 cycles -> busy stays high 32 cycles after release; all registers read their index.
REQ-038 NRD=4, INIT_MODE=0, DATA_W=16: all ports read R9 -> 0; write R9=0x1234 -> all four ports show 0x1234 in the same cycle.

Source files
------------

// File: rtl/mips_reg_bank_p.sv
// -----------------------------------------------------------------------------
// mips_reg_bank_p
//   Multi-read-port register bank with a hardware initialisation sweep.
//   After reset (or on init_req while idle) the bank walks every register,
//   one per clock, loading either zero or the register's own index.  While the
//   sweep runs the bank reports busy, reads return zero and user writes are
//   dropped (flagged on wr_drop).  In normal operation R0 is hard-wired to
//   zero, out-of-range indices read as zero and writes to them are ignored,
//   and a same-cycle write is forwarded to any read port addressing it.
//
// Ports
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous active-low reset
//   wr_en     in   1            write request
//   wr_addr   in   AW           write register index
//   wr_data   in   DATA_W       write data
//   rd_addr   in   NRD*AW       packed read indices, port i = [i*AW +: AW]
//   rd_data   out  NRD*DATA_W   packed combinational read data
//   init_req  in   1            starts a re-initialisation sweep when idle
//   clr_drop  in   1            clears wr_drop
//   busy      out  1            sweep in progress
//   wr_drop   out  1            sticky: a write was discarded during a sweep
// -----------------------------------------------------------------------------
module mips_reg_bank_p #(
   parameter  int DATA_W    = 32,
   parameter  int NREGS     = 32,
   parameter  int NRD       = 2,
   parameter  int INIT_MODE = 1,
   localparam int AW        = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic                  init_req,
   input  logic                  clr_drop,
   output logic                  busy,
   output logic                  wr_drop
);

   localparam int            DEPTH      = 1 << AW;
   // One bit per encodable index: set where the index names a real register.
   localparam logic [DEPTH-1:0] VALID_MASK = {DEPTH{1'b1}} >> (DEPTH - NREGS);
   localparam logic [AW-1:0] LAST_IDX   = AW'(NREGS - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t              state_r, state_n;
   logic [AW-1:0]       cnt_r, cnt_n;
   logic                wr_drop_r, wr_drop_n;
   logic [DATA_W-1:0]   mem_r [NREGS];
   logic [AW-1:0]       rd_idx_s [NRD];

   // Sweep fill value for a given register index.
   function automatic logic [DATA_W-1:0] init_val(input logic [AW-1:0] idx);
      if (INIT_MODE == 1) begin
         return DATA_W'(idx);
      end else begin
         return '0;
      end
   endfunction

   // Index names an architecturally writable/readable register (not R0, in range).
   function automatic logic live_idx(input logic [AW-1:0] idx);
      return (idx != '0) && VALID_MASK[idx];
   endfunction

   // Control state: FSM, sweep counter and sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_INIT;
         cnt_r     <= '0;
         wr_drop_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         cnt_r     <= cnt_n;
         wr_drop_r <= wr_drop_n;
      end
   end

   // Next-state logic; init_req is only honoured from IDLE so a sweep never restarts.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      wr_drop_n = wr_drop_r;
      case (state_r)
         ST_INIT: begin
            if (cnt_r == LAST_IDX) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n   = cnt_r + AW'(1);
            end
         end
         ST_IDLE: begin
            if (init_req) begin
               state_n = ST_INIT;
               cnt_n   = '0;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_INIT;
            cnt_n   = '0;
         end
      endcase
      // A dropped write outranks a same-cycle clear.
      if ((state_r == ST_INIT) && wr_en) begin
         wr_drop_n = 1'b1;
      end else if (clr_drop) begin
         wr_drop_n = 1'b0;
      end else begin
         wr_drop_n = wr_drop_r;
      end
   end

   // Storage: sweep writes in INIT, accepted user writes in IDLE. Contents are
   // deliberately not reset; reset parks the FSM in INIT so no user write lands.
   always_ff @(posedge clk) begin
      if (state_r == ST_INIT) begin
         mem_r[cnt_r] <= init_val(cnt_r);
      end else if (wr_en && live_idx(wr_addr)) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Unpack the per-port read indices.
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_idx_s[i] = rd_addr[i*AW +: AW];
      end
   end

   // Read ports: zero while sweeping, for R0 and for out-of-range indices;
   // otherwise the stored value, or the write data when this cycle writes it.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         if ((state_r == ST_IDLE) && live_idx(rd_idx_s[i])) begin
            if (wr_en && (wr_addr == rd_idx_s[i])) begin
               rd_data[i*DATA_W +: DATA_W] = wr_data;
            end else begin
               rd_data[i*DATA_W +: DATA_W] = mem_r[rd_idx_s[i]];
            end
         end else begin
            rd_data[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

   assign busy    = (state_r == ST_INIT);
   assign wr_drop = wr_drop_r;

endmodule
